// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO.
//   address    word select (DATA, RSVD, IRQMASK, EDGECAP)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data (1-cycle latency)
//   irq        level interrupt to the CPU
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO for switch/button banks: synchroniser, per-bit debounce,
// edge detection into a sticky W1C edge-capture register, maskable level irq.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata/irq)
//   in_port  raw asynchronous inputs, WIDTH bits

// One input bit: sync chain, debounce filter, edge detect, sticky capture flag.
module pio_in_edge_irq_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic armed,
  input  logic din,
  input  logic clr,
  output logic filtered,
  output logic cap
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   filt_d;
  logic                   edge_term;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // While unarmed both filtered and its delayed copy track sync, so the
  // first armed cycle sees no difference and power-up levels raise no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered <= 1'b0;
      filt_d   <= 1'b0;
      cnt      <= '0;
    end else if (!armed) begin
      filtered <= sync;
      filt_d   <= sync;
      cnt      <= '0;
    end else begin
      filt_d <= filtered;
      if (sync == filtered)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= sync;
        cnt      <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    edge_term = 1'b0;
    case (EDGE_TYPE)
      0:       edge_term =  filtered & ~filt_d;
      1:       edge_term = ~filtered &  filt_d;
      default: edge_term =  filtered ^  filt_d;
    endcase
    edge_term = edge_term & armed;
  end

  // New edge is OR'd after the clear, so an edge coinciding with W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap <= 1'b0;
    else          cap <= (cap & ~clr) | edge_term;
  end
endmodule

module pio_in_edge_irq #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_in_edge_irq_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port
);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  logic [AW-1:0]    arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Unarmed for SYNC_STAGES+1 cycles after reset so the sync chain fills
  // with the real input levels before debounce/edge logic engages.
  assign armed = (arm_cnt == AW'(SYNC_STAGES + 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign clr          = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_in_edge_irq_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .armed   (armed),
      .din     (in_port[i]),
      .clr     (clr[i]),
      .filtered(filtered[i]),
      .cap     (edge_capture[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              irq_mask <= '0;
    else if (wr_en && bus.address == 2'd2)     irq_mask <= bus.writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = filtered;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // Read is registered every cycle regardless of chipselect; no side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  assign bus.irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_pio_in_edge_irq.sv
module tb_pio_in_edge_irq;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] in0, in2;
  int         nvec = 0;
  int         nerr = 0;
  logic [31:0] r;

  pio_in_edge_irq_if bus0 ();
  pio_in_edge_irq_if bus2 ();

  pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0));
  pio_in_edge_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit d2, input logic [1:0] a, input logic [31:0] d);
    if (d2) begin
      bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
    end else begin
      bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    end
    tick();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic rd(input bit d2, input logic [1:0] a, output logic [31:0] v);
    if (d2) bus2.address = a; else bus0.address = a;
    tick();
    v = d2 ? bus2.readdata : bus0.readdata;
  endtask

  initial begin
    reset_n = 1'b0;
    in0 = 10'h3FF; in2 = 10'h3FF;
    bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;

    // 1: reset with all inputs high, no spurious edge after arming
    repeat (3) tick();
    chk("rst_rdata", bus0.readdata, 32'h0);
    chk("rst_irq", {31'h0, bus0.irq}, 32'h0);
    reset_n = 1'b1;
    repeat (8) tick();
    rd(0, 2'd0, r); chk("arm_data", r, 32'h3FF);
    rd(0, 2'd3, r); chk("arm_edgecap", r, 32'h0);
    chk("arm_irq", {31'h0, bus0.irq}, 32'h0);

    // 2: rising edge latency on bit0
    in0 = 10'h000;
    repeat (10) tick();
    rd(0, 2'd3, r); chk("fall_not_cap", r, 32'h0);
    wr(0, 2'd2, 32'h1);
    bus0.address = 2'd0;
    in0 = 10'h001;
    tick();                      // edge k
    repeat (4) tick();
    tick();                      // k+5
    chk("lat_data_k5", bus0.readdata, 32'h0);
    chk("lat_irq_k5", {31'h0, bus0.irq}, 32'h0);
    tick();                      // k+6
    chk("lat_data_k6", bus0.readdata, 32'h1);
    chk("lat_irq_k6", {31'h0, bus0.irq}, 32'h1);
    rd(0, 2'd3, r); chk("lat_edgecap", r, 32'h1);

    // 3: glitch rejection vs accepted pulse on bit5
    in0 = 10'h021; repeat (3) tick(); in0 = 10'h001;
    repeat (10) tick();
    rd(0, 2'd0, r); chk("glitch_data", r, 32'h001);
    rd(0, 2'd3, r); chk("glitch_edgecap", r, 32'h001);
    in0 = 10'h021; repeat (4) tick(); in0 = 10'h001;
    repeat (12) tick();
    rd(0, 2'd3, r); chk("pulse_edgecap", r, 32'h021);
    rd(0, 2'd0, r); chk("pulse_data", r, 32'h001);

    // 4: masking and W1C
    wr(0, 2'd3, 32'h3FF);
    rd(0, 2'd3, r); chk("clear_all", r, 32'h0);
    in0 = 10'h005;
    repeat (10) tick();
    rd(0, 2'd3, r); chk("bit2_cap", r, 32'h004);
    chk("masked_irq", {31'h0, bus0.irq}, 32'h0);
    wr(0, 2'd2, 32'h5);
    chk("unmasked_irq", {31'h0, bus0.irq}, 32'h1);
    wr(0, 2'd3, 32'h4);
    chk("w1c_irq", {31'h0, bus0.irq}, 32'h0);
    rd(0, 2'd3, r); chk("w1c_edgecap", r, 32'h0);

    // 5: W1C coinciding with a new edge leaves the bit set
    in0 = 10'h004;
    repeat (10) tick();
    in0 = 10'h005;
    tick();                      // edge k
    repeat (5) tick();           // k+5
    wr(0, 2'd3, 32'h1);          // write lands on k+6
    chk("race_irq", {31'h0, bus0.irq}, 32'h1);
    rd(0, 2'd3, r); chk("race_edgecap", r, 32'h001);

    // reserved address and upper bits
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, r); chk("rsvd_read", r, 32'h0);
    wr(0, 2'd2, 32'hFFFF_FC00);
    rd(0, 2'd2, r); chk("mask_hi_bits", r, 32'h0);
    chk("mask_hi_irq", {31'h0, bus0.irq}, 32'h0);
    wr(0, 2'd3, 32'hFFFF_FC00);
    rd(0, 2'd3, r); chk("w1c_hi_bits", r, 32'h001);

    // 6: any-edge capture, then reset mid-debounce
    in2 = 10'h1FF;
    repeat (10) tick();
    rd(1, 2'd3, r); chk("any_fall_cap", r, 32'h200);
    rd(1, 2'd0, r); chk("any_fall_data", r, 32'h1FF);
    wr(1, 2'd3, 32'h200);
    rd(1, 2'd3, r); chk("any_clr", r, 32'h0);
    in2 = 10'h3FF;
    repeat (10) tick();
    rd(1, 2'd3, r); chk("any_rise_cap", r, 32'h200);
    wr(1, 2'd2, 32'h200);
    chk("any_irq", {31'h0, bus2.irq}, 32'h1);
    in2 = 10'h1FF;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_rdata2", bus2.readdata, 32'h0);
    chk("midrst_irq2", {31'h0, bus2.irq}, 32'h0);
    chk("midrst_rdata0", bus0.readdata, 32'h0);
    chk("midrst_irq0", {31'h0, bus0.irq}, 32'h0);
    in2 = 10'h3FF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    rd(1, 2'd0, r); chk("post_data2", r, 32'h3FF);
    rd(1, 2'd3, r); chk("post_edgecap2", r, 32'h0);
    rd(1, 2'd2, r); chk("post_mask2", r, 32'h0);
    chk("post_irq2", {31'h0, bus2.irq}, 32'h0);
    rd(0, 2'd0, r); chk("post_data0", r, 32'h005);
    rd(0, 2'd3, r); chk("post_edgecap0", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
